// File: rtl/sscoreboard_if.sv
// Pipeline-to-scoreboard bundle: ID query/issue, writeback retire, and stall/busy/error status.
// The pipeline side takes the master modport; the scoreboard takes the slave modport.
interface sscoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] id_rs1_addr;
  logic [ADDR_WIDTH-1:0] id_rs2_addr;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [ADDR_WIDTH-1:0] id_rd_addr;
  logic                  id_writes_rd;
  logic                  issue_fire;
  logic                  issue_kill;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_rd_addr;
  logic                  stall_pipeline;
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  underflow_err;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_rd_addr, id_writes_rd, issue_fire, issue_kill,
           wb_valid, wb_rd_addr,
    input  stall_pipeline, busy_vec, underflow_err
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_rd_addr, id_writes_rd, issue_fire, issue_kill,
           wb_valid, wb_rd_addr,
    output stall_pipeline, busy_vec, underflow_err
  );
endinterface

// File: rtl/sscoreboard.sv
// Per-register pending-write counters; issue visible next cycle, writeback bypassed same cycle; stall is combinational.
// Optional SSCOREBOARD_WAW_CHECK_EN also stalls ID while its rd has any write outstanding.
module sscoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 3,
  parameter int ADDR_WIDTH  = 5
) (
  input logic          clk,
  input logic          rst,
  sscoreboard_if.slave sb
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  logic [CW-1:0]       count [NUM_REGS];
  logic [CW-1:0]       eff   [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                wb_eff;
  logic                iss_eff;
  logic                rd_tracked;
  logic                raw_stall;
  logic                struct_stall;
  logic                waw_stall;
  logic                stall;
  logic                underflow;
  logic                err_q;

  assign wb_eff     = sb.wb_valid && (sb.wb_rd_addr != '0);
  assign rd_tracked = sb.id_writes_rd && (sb.id_rd_addr != '0);

  // Same-cycle writeback bypass: the retiring write is already accounted for in queries.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      eff[r] = count[r];
      if (wb_eff && (sb.wb_rd_addr == ADDR_WIDTH'(r)) && (count[r] != '0))
        eff[r] = count[r] - CW'(1);
    end
  end

  assign raw_stall = (sb.id_uses_rs1 && (sb.id_rs1_addr != '0) && (eff[sb.id_rs1_addr] != '0)) ||
                     (sb.id_uses_rs2 && (sb.id_rs2_addr != '0) && (eff[sb.id_rs2_addr] != '0));

  assign struct_stall = rd_tracked && (eff[sb.id_rd_addr] == CW'(MAX_PENDING));

`ifdef SSCOREBOARD_WAW_CHECK_EN
  assign waw_stall = rd_tracked && (eff[sb.id_rd_addr] != '0);
`else
  assign waw_stall = 1'b0;
`endif

  assign stall   = raw_stall || struct_stall || waw_stall;
  assign iss_eff = sb.issue_fire && !sb.issue_kill && !stall && rd_tracked;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = iss_eff && (sb.id_rd_addr == ADDR_WIDTH'(r));
      dec_vec[r] = wb_eff && (sb.wb_rd_addr == ADDR_WIDTH'(r));
    end
  end

  // A matching issue in the same cycle absorbs the writeback, so no underflow then.
  assign underflow = wb_eff && (count[sb.wb_rd_addr] == '0) &&
                     !(iss_eff && (sb.id_rd_addr == sb.wb_rd_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        count[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          count[r] <= count[r] + CW'(1);
        else if (dec_vec[r] && !inc_vec[r] && (count[r] != '0))
          count[r] <= count[r] - CW'(1);
      end
      if (underflow)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    sb.busy_vec = '0;
    for (int r = 1; r < NUM_REGS; r++)
      sb.busy_vec[r] = (count[r] != '0);
  end

  assign sb.stall_pipeline = stall;
  assign sb.underflow_err  = err_q;

endmodule

// File: doc/sscoreboard.md
Name: sscoreboard

Overview:
Per-register pending-write tracker for multi-cycle producers: variable-latency loads and vector/multi-cycle ALU ops.
- Issue side writes entries: an instruction leaving ID marks its rd as pending.
- Writeback side clears them: each completing result retires one pending write on its rd.
- Read side answers RAW queries from ID and drives a stall to the pipeline control, complementing the single-cycle load-use detector.

Parameters:
NUM_REGS, 32, architectural registers tracked; index 0 is hardwired zero and never tracked.
MAX_PENDING, 3, maximum outstanding writes per register; counter width = $clog2(MAX_PENDING+1).
ADDR_WIDTH, 5, register address width.

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous, active-high reset.
id_rs1_addr  input  ADDR_WIDTH  source 1 of the instruction in ID.
id_rs2_addr  input  ADDR_WIDTH  source 2 of the instruction in ID.
id_uses_rs1  input  1  ID instruction reads rs1.
id_uses_rs2  input  1  ID instruction reads rs2.
id_rd_addr  input  ADDR_WIDTH  destination of the instruction in ID.
id_writes_rd  input  1  ID instruction is a tracked (multi-cycle) producer of rd.
issue_fire  input  1  ID instruction advances to EX this cycle.
issue_kill  input  1  squash the ID instruction this cycle (branch flush); it must not be recorded.
wb_valid  input  1  a tracked result is written back this cycle.
wb_rd_addr  input  ADDR_WIDTH  destination of that writeback.
stall_pipeline  output  1  ID must hold (combinational).
busy_vec  output  NUM_REGS  bit r = 1 when count[r] != 0 (registered state; bit 0 is always 0).
underflow_err  output  1  sticky; a writeback arrived for a register with count 0.

Behaviour:
- State: count[r] for r = 1..NUM_REGS-1, plus underflow_err.
- Reset (async, rst=1): all counts = 0, busy_vec = 0, underflow_err = 0. stall_pipeline then follows only the combinational rules below.
- Effective writeback: wb_eff = wb_valid && wb_rd_addr != 0.
- Effective issue: iss_eff = issue_fire && !issue_kill && !stall_pipeline && id_writes_rd && id_rd_addr != 0. An issue while stalled is ignored.
- RAW stall (combinational): stall_pipeline = 1 if a used source s != 0 has an effective count > 0.
  - Effective count = count[s] − (wb_eff && wb_rd_addr == s ? 1 : 0).
  - A writeback in the same cycle therefore releases the last pending write; the forwarding path supplies the data.
- Structural stall (combinational): stall_pipeline = 1 if id_writes_rd, id_rd_addr != 0 and effective count[id_rd_addr] == MAX_PENDING.
- Update at posedge clk, per register r:
  - iss_eff to r only: +1.
  - wb_eff to r only: −1 if count > 0. If count == 0: unchanged and underflow_err set.
  - Both to r in the same cycle: unchanged (a net +0; the structural rule has already guaranteed no overflow).
- Latency: an issue becomes visible to queries in the next cycle. A writeback is visible in the same cycle through the bypass.
- x0 is never recorded, never stalls, and a writeback to it is ignored without flagging an error.
- issue_kill squashes the ID instruction only. Entries already recorded remain until their writebacks arrive, because in-flight results still return.
- Reset asserted mid-operation clears all state immediately. Writebacks arriving after reset deassertion for pre-reset issues set underflow_err.

Optional Feature:
SSCOREBOARD_WAW_CHECK_EN.
- Defined: stall_pipeline additionally asserts when id_writes_rd, id_rd_addr != 0 and the effective count[id_rd_addr] > 0. This enforces in-order completion per register, and the structural rule becomes unreachable.
- Undefined: multiple outstanding writes to one rd are allowed up to MAX_PENDING; producers must write back in issue order.

Test Plan:
1. Reset, then issue rd=5 at cycle 0; ID reads rs1=5 at cycle 1 -> stall_pipeline=1 and busy_vec[5]=1. Issue wb rd=5 at cycle 3 -> stall_pipeline=0 in cycle 3; busy_vec[5]=0 from cycle 4.
2. Issue to rd=7 three times (MAX_PENDING=3), then a fourth issue to rd=7 -> stall_pipeline=1 and the count stays 3. Assert wb rd=7 in the same cycle -> stall drops and the count stays 3 (issue and writeback cancel).
3. issue_fire=1 with issue_kill=1 for rd=9 -> busy_vec[9] stays 0 and there is no later stall on rs2=9.
4. Issue targeting rd=0, and ID reading rs1=0 -> no state change and stall_pipeline=0. Writeback to rd=0 with count 0 -> underflow_err stays 0.
5. wb_valid for rd=12 with count 0 -> underflow_err=1 and it holds until rst. Assert rst asynchronously mid-cycle with counts nonzero -> busy_vec=0 and underflow_err=0 immediately.
6. With SSCOREBOARD_WAW_CHECK_EN defined: issue rd=4, then ID instruction writing rd=4 -> stall_pipeline=1 until wb rd=4. Without the macro -> no stall and count[4]=2.
